// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch controller for the IF stage: next-PC selection,
// a single-outstanding imem handshake and a small instruction buffer toward ID.
module pc_fetch_unit #(
  parameter int              XLEN         = 32,
  parameter int              ILEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              PC_STEP      = 4,
  parameter int              ALIGN_BITS   = 2,
  parameter int              IBUF_DEPTH   = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [ILEN-1:0] imem_rdata,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [ILEN-1:0] if_instr,
  input  logic            if_ready
);

  localparam int PTR_W = $clog2(IBUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [XLEN-1:0] ALIGN_MASK = {XLEN{1'b1}} << ALIGN_BITS;

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

  state_t           state;
  logic [XLEN-1:0]  pc_q;
  logic [XLEN-1:0]  addr_q;
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [XLEN-1:0]  buf_pc    [IBUF_DEPTH];
  logic [ILEN-1:0]  buf_instr [IBUF_DEPTH];

  logic             flush;
  logic             push;
  logic             pop;
  logic             room_after_ack;
  logic [XLEN-1:0]  target;
  logic [XLEN-1:0]  pc_seq;
  logic [CNT_W-1:0] count_upd;
  logic [CNT_W:0]   count_after_ack;

  // Trap outranks redirect; occupancy after an ack decides whether to keep fetching.
  always_comb begin
    flush           = trap_valid || redirect_valid;
    target          = (trap_valid ? trap_pc : redirect_pc) & ALIGN_MASK;
    pc_seq          = pc_q + XLEN'(PC_STEP);
    pop             = if_valid && if_ready;
    push            = (state == REQ) && imem_ack && !flush;
    count_upd       = count + CNT_W'(push) - CNT_W'(pop);
    count_after_ack = {1'b0, count} + (CNT_W+1)'(1) - (CNT_W+1)'(pop);
    room_after_ack  = count_after_ack < (CNT_W+1)'(IBUF_DEPTH);
  end

  assign imem_req  = (state == REQ) || (state == DRAIN);
  assign imem_addr = addr_q;
  assign if_valid  = (count != '0);
  assign if_pc     = if_valid ? buf_pc[rd_ptr] : '0;
  assign if_instr  = if_valid ? buf_instr[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      buf_pc[wr_ptr]    <= addr_q;
      buf_instr[wr_ptr] <= imem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      pc_q   <= RESET_VECTOR;
      addr_q <= RESET_VECTOR;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (flush) begin
      pc_q   <= target;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      // An unacked fetch must still complete on the bus, so its reply is drained and dropped.
      case (state)
        REQ: begin
          if (imem_ack) begin
            addr_q <= target;
            state  <= REQ;
          end else begin
            state <= DRAIN;
          end
        end
        IDLE:    state <= IDLE;
        DRAIN:   state <= DRAIN;
        default: state <= IDLE;
      endcase
    end else begin
      count <= count_upd;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case (state)
        IDLE: begin
          if (count < CNT_W'(IBUF_DEPTH)) begin
            addr_q <= pc_q;
            state  <= REQ;
          end
        end
        REQ: begin
          if (imem_ack) begin
            pc_q <= pc_seq;
            if (room_after_ack) begin
              addr_q <= pc_seq;
              state  <= REQ;
            end else begin
              state <= IDLE;
            end
          end
        end
        DRAIN: begin
          if (imem_ack) begin
            addr_q <= pc_q;
            state  <= REQ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: scoreboard of expected PCs, one task per scenario.
// A second instance with a wrapping reset vector checks address roll-over.
module tb_pc_fetch_unit;

  localparam logic [31:0] MAGIC = 32'hA5A5A5A5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        trap_valid = 1'b0;
  logic [31:0] trap_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_ready = 1'b0;

  logic        ack_mode = 1'b1;
  logic        ack_en = 1'b0;
  logic        ack_raw = 1'b0;

  logic        w_req;
  logic [31:0] w_addr;
  logic        w_valid;
  logic [31:0] w_pc;
  logic [31:0] w_instr;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  logic [31:0] w_exp_q[$];

  always #5 clk = ~clk;

  // Memory model: zero-wait when enabled, or a free-running random ack during reset.
  assign imem_ack   = ack_mode ? (imem_req && ack_en) : ack_raw;
  assign imem_rdata = imem_addr ^ MAGIC;

  pc_fetch_unit #(
    .XLEN(32), .ILEN(32), .RESET_VECTOR(32'h0), .PC_STEP(4), .ALIGN_BITS(2), .IBUF_DEPTH(2)
  ) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .trap_valid(trap_valid), .trap_pc(trap_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr), .if_ready(if_ready)
  );

  pc_fetch_unit #(
    .XLEN(32), .ILEN(32), .RESET_VECTOR(32'hFFFFFFFC), .PC_STEP(4), .ALIGN_BITS(2), .IBUF_DEPTH(2)
  ) dut_wrap (
    .clk(clk), .rst(rst),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .trap_valid(1'b0), .trap_pc(32'h0),
    .imem_req(w_req), .imem_addr(w_addr), .imem_ack(w_req), .imem_rdata(w_addr ^ MAGIC),
    .if_valid(w_valid), .if_pc(w_pc), .if_instr(w_instr), .if_ready(1'b1)
  );

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; ack_mode = 1'b1; ack_en = 1'b0; if_ready = 1'b0;
    redirect_valid = 1'b0; trap_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ack_mode = 1'b0; ack_en = 1'b0; if_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ack_raw = 1'($urandom);
      #1;
      checks++;
      if (imem_req !== 1'b0 || if_valid !== 1'b0 || imem_addr !== 32'h0) begin
        errors++;
        $display("[TB] FAIL reset_hold cycle %0d: req=%b valid=%b addr=%h, required 0 0 00000000",
                 i, imem_req, if_valid, imem_addr);
      end
      checks++;
      if (if_pc !== 32'h0 || if_instr !== 32'h0) begin
        errors++;
        $display("[TB] FAIL reset_head cycle %0d: pc=%h instr=%h, required 0 0", i, if_pc, if_instr);
      end
    end
    @(negedge clk);
    rst = 1'b0; ack_mode = 1'b1; ack_raw = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL release_c1: req=%b, required 0", imem_req);
    end
    @(negedge clk);
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++;
      $display("[TB] FAIL release_c2: req=%b addr=%h, required 1 00000000", imem_req, imem_addr);
    end
  endtask

  task automatic test_streaming();
    logic [31:0] exp_fetch;
    logic [31:0] e;
    int pops = 0;
    int last_pop = -1;
    int first_req = -1;
    int first_valid = -1;
    do_reset();
    exp_q.delete();
    for (int k = 0; k < 4; k++) exp_q.push_back(32'(k * 4));
    exp_fetch = 32'h0;
    for (int cyc = 0; cyc < 20 && pops < 4; cyc++) begin
      if (cyc != 0) @(negedge clk);
      ack_en = 1'b1; if_ready = 1'b1;
      #1;
      if (imem_req && imem_ack) begin
        if (first_req < 0) first_req = cyc;
        checks++;
        if (imem_addr !== exp_fetch) begin
          errors++;
          $display("[TB] FAIL stream_addr: addr=%h, required %h", imem_addr, exp_fetch);
        end
        exp_fetch += 32'd4;
      end
      if (if_valid && if_ready) begin
        if (first_valid < 0) first_valid = cyc;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL stream_pop: unexpected pc=%h, required no pop", if_pc);
        end else begin
          e = exp_q.pop_front();
          if (if_pc !== e || if_instr !== (e ^ MAGIC)) begin
            errors++;
            $display("[TB] FAIL stream_pop: pc=%h instr=%h, required pc=%h instr=%h",
                     if_pc, if_instr, e, e ^ MAGIC);
          end
        end
        if (last_pop >= 0) begin
          checks++;
          if (cyc != last_pop + 1) begin
            errors++;
            $display("[TB] FAIL stream_gap: pop at cycle %0d, required %0d", cyc, last_pop + 1);
          end
        end
        last_pop = cyc;
        pops++;
      end
    end
    checks++;
    if (pops != 4) begin
      errors++;
      $display("[TB] FAIL stream_count: pops=%0d, required 4", pops);
    end
    checks++;
    if (first_req != 1 || first_valid != 2) begin
      errors++;
      $display("[TB] FAIL stream_latency: first_req=%0d first_valid=%0d, required 1 2",
               first_req, first_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_fetch;
    logic [31:0] e;
    int acks = 0;
    int pops = 0;
    do_reset();
    exp_fetch = 32'h0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      if (cyc != 0) @(negedge clk);
      ack_en = 1'b1; if_ready = 1'b0;
      #1;
      if (imem_req && imem_ack) begin
        acks++;
        checks++;
        if (imem_addr !== exp_fetch) begin
          errors++;
          $display("[TB] FAIL bp_addr: addr=%h, required %h", imem_addr, exp_fetch);
        end
        exp_fetch += 32'd4;
      end
    end
    checks++;
    if (acks != 2) begin
      errors++;
      $display("[TB] FAIL bp_acks: acks=%0d, required 2", acks);
    end
    checks++;
    if (imem_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_stall: req=%b, required 0", imem_req);
    end
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h0) begin
      errors++;
      $display("[TB] FAIL bp_head: valid=%b pc=%h, required 1 00000000", if_valid, if_pc);
    end
    exp_q.delete();
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
    exp_fetch = 32'h8;
    for (int cyc = 0; cyc < 20 && pops < 3; cyc++) begin
      @(negedge clk);
      ack_en = 1'b1; if_ready = 1'b1;
      #1;
      if (imem_req && imem_ack) begin
        checks++;
        if (imem_addr !== exp_fetch) begin
          errors++;
          $display("[TB] FAIL bp_resume_addr: addr=%h, required %h", imem_addr, exp_fetch);
        end
        exp_fetch += 32'd4;
      end
      if (if_valid && if_ready) begin
        pops++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL bp_pop: unexpected pc=%h, required no pop", if_pc);
        end else begin
          e = exp_q.pop_front();
          if (if_pc !== e || if_instr !== (e ^ MAGIC)) begin
            errors++;
            $display("[TB] FAIL bp_pop: pc=%h instr=%h, required pc=%h instr=%h",
                     if_pc, if_instr, e, e ^ MAGIC);
          end
        end
      end
    end
    checks++;
    if (pops != 3) begin
      errors++;
      $display("[TB] FAIL bp_count: pops=%0d, required 3", pops);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    ack_en = 1'b1; if_ready = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1; ack_mode = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      ack_raw = 1'($urandom);
      #1;
      checks++;
      if (imem_req !== 1'b0 || if_valid !== 1'b0 || imem_addr !== 32'h0) begin
        errors++;
        $display("[TB] FAIL mid_reset cycle %0d: req=%b valid=%b addr=%h, required 0 0 00000000",
                 i, imem_req, if_valid, imem_addr);
      end
    end
    @(negedge clk);
    rst = 1'b0; ack_mode = 1'b1; ack_en = 1'b0; ack_raw = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || if_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_reset_restart: req=%b addr=%h valid=%b, required 1 00000000 0",
               imem_req, imem_addr, if_valid);
    end
  endtask

  task automatic test_redirect();
    logic [31:0] e;
    logic found = 1'b0;
    logic first_chk = 1'b1;
    int pops = 0;
    do_reset();
    exp_q.delete();
    exp_q.push_back(32'h0);
    for (int cyc = 0; cyc < 20 && !found; cyc++) begin
      if (cyc != 0) @(negedge clk);
      if (imem_req && imem_addr == 32'h8) begin
        found = 1'b1;
        ack_en = 1'b0; if_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h100;
      end else begin
        ack_en = 1'b1; if_ready = 1'b1;
      end
      #1;
      if (if_valid && if_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL redir_pre_pop: unexpected pc=%h, required no pop", if_pc);
        end else begin
          e = exp_q.pop_front();
          if (if_pc !== e) begin
            errors++;
            $display("[TB] FAIL redir_pre_pop: pc=%h, required %h", if_pc, e);
          end
        end
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("[TB] FAIL redir_setup: fetch at 00000008 seen=0, required 1");
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      redirect_valid = 1'b0;
      #1;
      checks++;
      if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h8) begin
        errors++;
        $display("[TB] FAIL redir_drain cycle %0d: valid=%b req=%b addr=%h, required 0 1 00000008",
                 i, if_valid, imem_req, imem_addr);
      end
    end
    @(negedge clk);
    ack_en = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h8 || imem_ack !== 1'b1) begin
      errors++;
      $display("[TB] FAIL redir_drain_ack: req=%b addr=%h ack=%b, required 1 00000008 1",
               imem_req, imem_addr, imem_ack);
    end
    exp_q.delete();
    exp_q.push_back(32'h100); exp_q.push_back(32'h104);
    for (int cyc = 0; cyc < 20 && pops < 2; cyc++) begin
      @(negedge clk);
      ack_en = 1'b1; if_ready = 1'b1;
      #1;
      if (first_chk && imem_req) begin
        first_chk = 1'b0;
        checks++;
        if (imem_addr !== 32'h100) begin
          errors++;
          $display("[TB] FAIL redir_target: addr=%h, required 00000100", imem_addr);
        end
      end
      if (if_valid && if_ready) begin
        pops++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL redir_pop: unexpected pc=%h, required no pop", if_pc);
        end else begin
          e = exp_q.pop_front();
          if (if_pc !== e || if_instr !== (e ^ MAGIC)) begin
            errors++;
            $display("[TB] FAIL redir_pop: pc=%h instr=%h, required pc=%h instr=%h",
                     if_pc, if_instr, e, e ^ MAGIC);
          end
        end
      end
    end
    checks++;
    if (pops != 2) begin
      errors++;
      $display("[TB] FAIL redir_count: pops=%0d, required 2", pops);
    end
  endtask

  task automatic test_priority();
    logic [31:0] e;
    int pops = 0;
    do_reset();
    trap_valid = 1'b1; trap_pc = 32'h80;
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    ack_en = 1'b0; if_ready = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL prio_c1: req=%b, required 0", imem_req);
    end
    @(negedge clk);
    trap_valid = 1'b0; redirect_valid = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b0 || if_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL prio_idle: req=%b valid=%b, required 0 0", imem_req, if_valid);
    end
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h103; ack_en = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h80) begin
      errors++;
      $display("[TB] FAIL prio_trap: req=%b addr=%h, required 1 00000080", imem_req, imem_addr);
    end
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h100 || if_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL prio_align: req=%b addr=%h valid=%b, required 1 00000100 0",
               imem_req, imem_addr, if_valid);
    end
    exp_q.delete();
    exp_q.push_back(32'h100); exp_q.push_back(32'h104);
    for (int cyc = 0; cyc < 20 && pops < 2; cyc++) begin
      @(negedge clk);
      ack_en = 1'b1; if_ready = 1'b1;
      #1;
      if (if_valid && if_ready) begin
        pops++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL prio_pop: unexpected pc=%h, required no pop", if_pc);
        end else begin
          e = exp_q.pop_front();
          if (if_pc !== e || if_instr !== (e ^ MAGIC)) begin
            errors++;
            $display("[TB] FAIL prio_pop: pc=%h instr=%h, required pc=%h instr=%h",
                     if_pc, if_instr, e, e ^ MAGIC);
          end
        end
      end
    end
    checks++;
    if (pops != 2) begin
      errors++;
      $display("[TB] FAIL prio_count: pops=%0d, required 2", pops);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_fetch;
    logic [31:0] e;
    int pops = 0;
    int fetches = 0;
    do_reset();
    w_exp_q.delete();
    w_exp_q.push_back(32'hFFFFFFFC); w_exp_q.push_back(32'h0); w_exp_q.push_back(32'h4);
    exp_fetch = 32'hFFFFFFFC;
    for (int cyc = 0; cyc < 20 && pops < 3; cyc++) begin
      if (cyc != 0) @(negedge clk);
      #1;
      if (w_req && fetches < 3) begin
        fetches++;
        checks++;
        if (w_addr !== exp_fetch) begin
          errors++;
          $display("[TB] FAIL wrap_addr: addr=%h, required %h", w_addr, exp_fetch);
        end
        exp_fetch += 32'd4;
      end
      if (w_valid) begin
        pops++;
        checks++;
        if (w_exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL wrap_pop: unexpected pc=%h, required no pop", w_pc);
        end else begin
          e = w_exp_q.pop_front();
          if (w_pc !== e || w_instr !== (e ^ MAGIC)) begin
            errors++;
            $display("[TB] FAIL wrap_pop: pc=%h instr=%h, required pc=%h instr=%h",
                     w_pc, w_instr, e, e ^ MAGIC);
          end
        end
      end
    end
    checks++;
    if (pops != 3) begin
      errors++;
      $display("[TB] FAIL wrap_count: pops=%0d, required 3", pops);
    end
  endtask

  initial begin
    $display("[TB] starting pc_fetch_unit bench");
    test_reset();
    test_streaming();
    test_backpressure();
    test_mid_reset();
    test_redirect();
    test_priority();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: bench still running at %0t, required completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
